// File: rtl/dmem_dump_reader_if.sv
// Bus bundle for dmem_dump_reader: the data-memory read port (address out,
// combinational read data in) and the valid/ready word stream toward the
// consumer. master = dump reader, slave = memory plus consumer.
interface dmem_dump_reader_if;
  logic [31:0] mem_adr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_adr;

  modport master (
    output mem_adr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_adr
  );

  modport slave (
    input  mem_adr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_adr
  );
endinterface

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: while holding the CPU in reset, walks a word-aligned
// range of data memory and streams each word (with its byte address) over a
// valid/ready interface. Memory is only ever read; read data is combinational
// from mem_adr and is sampled one edge after the address was updated.
module dmem_dump_reader #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] num_words,
  output logic                 hold_cpu,
  output logic                 busy,
  output logic                 done,
  dmem_dump_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]          ADDR_INC = 32'(ADDR_STEP);

  state_t                 state_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [31:0]            mem_adr_r;
  logic [31:0]            out_data_r;
  logic [31:0]            out_adr_r;
  logic                   out_valid_r;
  logic                   hold_cpu_r;
  logic                   done_r;

  // Byte-offset bits of the base are deliberately discarded.
  logic unused_base_s;
  assign unused_base_s = ^base_addr[1:0];

  // Dump sequencer: state, address/counter walk, captured word and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      mem_adr_r   <= 32'h0000_0000;
      out_data_r  <= 32'h0000_0000;
      out_adr_r   <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      hold_cpu_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      // done is a single-cycle pulse raised only on the transition into DONE
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (num_words != CNT_ZERO) begin
              mem_adr_r  <= {base_addr[31:2], 2'b00};
              cnt_r      <= num_words;
              hold_cpu_r <= 1'b1;
              state_r    <= FETCH;
            end else begin
              // empty dump: report completion without touching the CPU or memory
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        FETCH: begin
          if (abort) begin
            out_valid_r <= 1'b0;
            hold_cpu_r  <= 1'b0;
            state_r     <= IDLE;
          end else begin
            // mem_adr has been stable for a full cycle, so read data is settled
            out_data_r  <= bus.mem_rdata;
            out_adr_r   <= mem_adr_r;
            out_valid_r <= 1'b1;
            state_r     <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            // abort wins over a same-cycle handshake
            out_valid_r <= 1'b0;
            hold_cpu_r  <= 1'b0;
            state_r     <= IDLE;
          end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (cnt_r == CNT_ONE) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              // address wraps naturally modulo 2^32
              mem_adr_r <= mem_adr_r + ADDR_INC;
              cnt_r     <= cnt_r - CNT_ONE;
              state_r   <= FETCH;
            end
          end else begin
            // backpressure: word, address and valid stay put
            state_r <= SEND;
          end
        end

        DONE: begin
          hold_cpu_r <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          out_valid_r <= 1'b0;
          hold_cpu_r  <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_r == FETCH) || (state_r == SEND);
  assign hold_cpu      = hold_cpu_r;
  assign done          = done_r;
  assign bus.mem_adr   = mem_adr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_adr   = out_adr_r;

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Read-side counterpart to the external data-memory write port of the CPU test top. While the CPU is held in reset, it walks a word-aligned range of data memory and streams each word out over a valid/ready interface for bench checking or host upload. The block drives the CPU hold (reset) and the external data address, and samples the memory's combinational read data. It never writes memory.

## Interface
- CNT_WIDTH, 16, width of the word-count input and the internal remaining-word counter.
- ADDR_STEP, 4, byte increment between consecutive words.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low. 0 forces the reset state below.
- start  input  1  one-cycle request to begin a dump. Sampled only in IDLE.
- abort  input  1  synchronous cancel. Honoured in FETCH and SEND.
- base_addr  input  32  first byte address. Bits [1:0] are ignored and treated as 0.
- num_words  input  CNT_WIDTH  number of words to dump.
- hold_cpu  output  1  active-high CPU hold; drives the top-level CPU reset and external-address select.
- mem_adr  output  32  drives Ext_DataAdr.
- mem_rdata  input  32  data-memory ReadData (combinational read of mem_adr).
- out_valid  output  1  out_data and out_adr hold a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  32  word read from memory.
- out_adr  output  32  byte address of out_data.
- busy  output  1  high in FETCH and SEND.
- done  output  1  one-cycle pulse when a dump completes normally.

## Operation
- Reset values: state IDLE; hold_cpu, out_valid, busy and done all 0; mem_adr, out_data and out_adr all 0; counter 0.
- States are IDLE, FETCH, SEND and DONE.
- IDLE, on start with num_words != 0:
  - latch mem_adr <= {base_addr[31:2],2'b00} and counter <= num_words;
  - set hold_cpu <= 1;
  - go to FETCH.
- IDLE, on start with num_words == 0: go to DONE. No hold and no memory access.
- FETCH: capture out_data <= mem_rdata, out_adr <= mem_adr and out_valid <= 1, then go to SEND.
- SEND, on out_valid && out_ready: clear out_valid.
  - If counter == 1, go to DONE.
  - Otherwise mem_adr <= mem_adr + ADDR_STEP, counter <= counter − 1, and go to FETCH.
- SEND without out_ready: hold out_data, out_adr and out_valid stable indefinitely.
- DONE: done = 1 for exactly one cycle, hold_cpu <= 0, then go to IDLE.
- abort in FETCH or SEND: next state is IDLE, out_valid <= 0, hold_cpu <= 0, and done is not pulsed. abort has priority over an out_ready handshake in the same cycle.
- start outside IDLE is ignored. abort in IDLE or DONE has no effect.
- mem_adr increments modulo 2^32, so 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- out_data and out_adr keep their last values after completion or abort.

## Timing
- Start-to-first-word latency: start sampled at edge N gives hold_cpu=1 and mem_adr valid after N. The FETCH capture happens at edge N+1, so out_valid=1 after N+1.
- mem_rdata must settle within one cycle of a mem_adr change. It is sampled only in FETCH, exactly one edge after mem_adr was updated.
- Throughput: one word per 2 cycles with out_ready held at 1.
- Total time for K words with out_ready=1: 2K cycles from the start edge to the DONE entry. done is asserted in the following cycle, and hold_cpu falls on the edge that leaves DONE.
- busy = (state==FETCH || state==SEND). It is combinational from state.
- Asynchronous reset mid-dump: all outputs go to their reset values immediately, and hold_cpu drops without a done pulse.

## Test plan
- Preload memory via Ext_MemWrite with 0x100→0xA5A5_0001, 0x104→0xA5A5_0002 and 0x108→0xA5A5_0003. Then start with base=0x100, num=3, out_ready=1 → three words in order with out_adr 0x100, 0x104, 0x108. done pulses on cycle 7 after start; hold_cpu is high from cycle 1 to cycle 7.
- Backpressure: same dump with out_ready low for 5 cycles on word 2 → out_data=0xA5A5_0002 held stable while out_valid stays high. There is no skip or duplicate, and the total is 3 words.
- Misaligned base: base=0x103, num=1 → out_adr=0x100 and out_data is the word at 0x100.
- Zero length and ignored start: num=0 → done pulses 1 cycle after start, hold_cpu and out_valid never assert. A start pulse mid-dump does not restart the dump.
- Abort and reset: abort during SEND of word 2 of 4 → IDLE next cycle, no done, hold_cpu=0. Asserting reset=0 mid-dump → all outputs 0 immediately.
- Wrap: base=0xFFFF_FFFC, num=2 → out_adr values are 0xFFFF_FFFC then 0x0000_0000.
